// File: rtl/pwm_ramp_gen.sv
// pwm_ramp_gen
//
// Stimulus generator for the discrete ADC loop. A duty code is swept upward
// from 0 to full scale. Each code is held for SETTLE_PERIODS PWM periods so
// the external RC filter can settle. At the end of each settle window a strobe
// is pulsed and the settled code is presented to the comparator-capture logic.
//
// Parameters
//   WIDTH          : duty code resolution; one PWM period is 2^WIDTH clk cycles
//   SETTLE_PERIODS : PWM periods each code is held before sampling (>= 1)
//
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   start       : begin a sweep (only looked at in IDLE)
//   stop        : abort the sweep and return to IDLE
//   continuous  : wrap to code 0 after full scale instead of stopping
//   pwm_out     : PWM drive to the RC filter
//   duty_code   : code currently being driven
//   sample_code : code whose settle window just ended (valid with step_strobe)
//   step_strobe : one-cycle pulse at the end of each settle window
//   sweep_done  : one-cycle pulse together with the full-scale code's strobe
//   busy        : high while sweeping
module pwm_ramp_gen #(
  parameter int WIDTH          = 8,
  parameter int SETTLE_PERIODS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty_code,
  output logic [WIDTH-1:0] sample_code,
  output logic             step_strobe,
  output logic             sweep_done,
  output logic             busy
);

  // A single settle period still needs a 1-bit counter to keep widths legal.
  localparam int PERIOD_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SETTLE_PERIODS - 1);
  localparam logic [WIDTH-1:0]    CODE_MAX    = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_reg;
  logic [WIDTH-1:0]      pwm_cnt_reg;
  logic [PERIOD_W-1:0]   period_cnt_reg;

  logic [WIDTH-1:0]      pwm_cnt_next;
  logic [PERIOD_W-1:0]   period_cnt_inc;
  logic [WIDTH-1:0]      duty_inc;
  logic                  period_wrap;
  logic                  terminal;
  logic                  code_last;

  // pwm_cnt_next relies on natural modulo-2^WIDTH wrap of the adder.
  assign pwm_cnt_next   = pwm_cnt_reg + WIDTH'(1);
  assign period_cnt_inc = period_cnt_reg + PERIOD_W'(1);
  assign duty_inc       = duty_code + WIDTH'(1);
  assign period_wrap    = (pwm_cnt_reg == CODE_MAX);
  assign terminal       = period_wrap && (period_cnt_reg == PERIOD_LAST);
  assign code_last      = (duty_code == CODE_MAX);

  // pwm_out is registered, so each branch computes the level that belongs to
  // the counter/code values it is loading: high while pwm_cnt < duty_code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pwm_cnt_reg    <= '0;
      period_cnt_reg <= '0;
      duty_code      <= '0;
      sample_code    <= '0;
      pwm_out        <= 1'b0;
      step_strobe    <= 1'b0;
      sweep_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction: cleared every cycle
      // unless the terminal branch below sets them again.
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;

      case (state_reg)
        IDLE: begin
          pwm_cnt_reg    <= '0;
          period_cnt_reg <= '0;
          duty_code      <= '0;
          pwm_out        <= 1'b0;
          busy           <= 1'b0;
          // stop has priority, so start+stop together keeps us idle.
          if (start && !stop) begin
            state_reg <= RUN;
            busy      <= 1'b1;
          end
        end

        RUN: begin
          if (stop) begin
            // Abort wins over a coincident terminal cycle; sample_code keeps
            // the last settled value for whoever still wants it.
            state_reg      <= IDLE;
            pwm_cnt_reg    <= '0;
            period_cnt_reg <= '0;
            duty_code      <= '0;
            pwm_out        <= 1'b0;
            busy           <= 1'b0;
          end else if (terminal) begin
            sample_code    <= duty_code;
            step_strobe    <= 1'b1;
            pwm_cnt_reg    <= '0;
            period_cnt_reg <= '0;
            duty_code      <= duty_inc;
            // New period starts at pwm_cnt=0 with code+1, which is nonzero
            // unless the code wraps from full scale.
            pwm_out        <= !code_last;
            if (code_last) begin
              sweep_done <= 1'b1;
              if (!continuous) begin
                state_reg <= IDLE;
                duty_code <= '0;
                pwm_out   <= 1'b0;
                busy      <= 1'b0;
              end
            end
          end else begin
            pwm_cnt_reg <= pwm_cnt_next;
            if (period_wrap) begin
              period_cnt_reg <= period_cnt_inc;
            end
            pwm_out <= (pwm_cnt_next < duty_code);
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Self-checking bench for pwm_ramp_gen with WIDTH=4, SETTLE_PERIODS=2.
// Cycle numbering: the edge that accepts start is edge 0; cycle N is the
// interval following edge N-1, so the first RUN cycle is cycle 1.
module tb_pwm_ramp_gen;

  localparam int W  = 4;
  localparam int SP = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         continuous = 1'b0;
  logic         pwm_out;
  logic [W-1:0] duty_code;
  logic [W-1:0] sample_code;
  logic         step_strobe;
  logic         sweep_done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pwm_ramp_gen #(.WIDTH(W), .SETTLE_PERIODS(SP)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .continuous(continuous),
    .pwm_out(pwm_out),
    .duty_code(duty_code),
    .sample_code(sample_code),
    .step_strobe(step_strobe),
    .sweep_done(sweep_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Advance to an absolute cycle number, counting strobes seen on the way.
  task automatic advance_to(input int target, output int strobes);
    strobes = 0;
    while (cyc < target) begin
      tick();
      if (step_strobe === 1'b1) strobes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({pwm_out, duty_code, sample_code, step_strobe, sweep_done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {pwm_out, duty_code, sample_code, step_strobe, sweep_done, busy});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %0b expected 0", busy);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_settle_timing();
    int n;
    do_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL settle_busy_c1: got %0b expected 1", busy); end
    checks++;
    if (duty_code !== 4'd0) begin errors++; $display("FAIL settle_duty_c1: got %0d expected 0", duty_code); end
    advance_to(32, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL settle_early_strobe: got %0d expected 0", n); end
    tick();
    checks++;
    if (step_strobe !== 1'b1) begin errors++; $display("FAIL settle_strobe_c33: got %0b expected 1", step_strobe); end
    checks++;
    if (sample_code !== 4'd0) begin errors++; $display("FAIL settle_sample_c33: got %0d expected 0", sample_code); end
    checks++;
    if (duty_code !== 4'd1) begin errors++; $display("FAIL settle_duty_c33: got %0d expected 1", duty_code); end
    advance_to(64, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL settle_gap_strobe: got %0d expected 0", n); end
    tick();
    checks++;
    if (step_strobe !== 1'b1 || sample_code !== 4'd1) begin
      errors++;
      $display("FAIL settle_strobe_c65: got strobe=%0b sample=%0d expected strobe=1 sample=1",
               step_strobe, sample_code);
    end
    $display("settle: strobes at cycles 33 and 65");
    stop_run();
  endtask

  task automatic test_full_sweep();
    int k;
    logic prev;
    k = 0;
    prev = 1'b0;
    continuous = 1'b0;
    do_start();
    while (cyc < 520) begin
      tick();
      if (step_strobe === 1'b1) begin
        $display("sweep: strobe %0d at cycle %0d sample=%0d done=%0b", k, cyc, sample_code, sweep_done);
        checks++;
        if (cyc !== 33 + 32 * k) begin errors++; $display("FAIL sweep_strobe_cycle: got %0d expected %0d", cyc, 33 + 32 * k); end
        checks++;
        if (sample_code !== 4'(k)) begin errors++; $display("FAIL sweep_sample: got %0d expected %0d", sample_code, k); end
        checks++;
        if (sweep_done !== (k == 15)) begin errors++; $display("FAIL sweep_done_flag: got %0b expected %0b", sweep_done, (k == 15)); end
        if (k == 15) begin
          checks++;
          if (busy !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end_idle: got busy=%0b pwm=%0b expected 0 0", busy, pwm_out);
          end
        end
        k++;
      end else if (sweep_done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL sweep_done_alone: got 1 at cycle %0d expected 0", cyc);
      end
      if (prev === 1'b1 && step_strobe === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL sweep_strobe_twice: got 2 consecutive at cycle %0d expected 1", cyc);
      end
      prev = step_strobe;
    end
    checks++;
    if (k !== 16) begin errors++; $display("FAIL sweep_strobe_count: got %0d expected 16", k); end
    checks++;
    if (busy !== 1'b0 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL sweep_after_idle: got busy=%0b pwm=%0b expected 0 0", busy, pwm_out);
    end
  endtask

  task automatic test_pwm_duty();
    int code, pos, highs0, highs5, highs15;
    logic exp_pwm;
    highs0 = 0;
    highs5 = 0;
    highs15 = 0;
    do_start();
    forever begin
      pos = cyc - 1;
      code = pos / 32;
      exp_pwm = ((pos % 16) < code);
      checks++;
      if (duty_code !== 4'(code)) begin errors++; $display("FAIL pwm_duty_code c%0d: got %0d expected %0d", cyc, duty_code, code); end
      if (code == 0 || code == 5 || code == 15) begin
        checks++;
        if (pwm_out !== exp_pwm) begin
          errors++;
          $display("FAIL pwm_level code%0d c%0d: got %0b expected %0b", code, cyc, pwm_out, exp_pwm);
        end
      end
      if (pwm_out === 1'b1) begin
        if (code == 0) highs0++;
        if (code == 5) highs5++;
        if (code == 15) highs15++;
      end
      if (cyc == 512) break;
      tick();
    end
    checks++;
    if (highs0 !== 0) begin errors++; $display("FAIL pwm_highs_code0: got %0d expected 0", highs0); end
    checks++;
    if (highs5 !== 10) begin errors++; $display("FAIL pwm_highs_code5: got %0d expected 10", highs5); end
    checks++;
    if (highs15 !== 30) begin errors++; $display("FAIL pwm_highs_code15: got %0d expected 30", highs15); end
    $display("pwm: high counts code0=%0d code5=%0d code15=%0d", highs0, highs5, highs15);
    stop_run();
  endtask

  task automatic test_continuous();
    int n;
    continuous = 1'b1;
    do_start();
    advance_to(512, n);
    tick();
    checks++;
    if (sweep_done !== 1'b1 || step_strobe !== 1'b1 || sample_code !== 4'd15) begin
      errors++;
      $display("FAIL cont_done: got done=%0b strobe=%0b sample=%0d expected 1 1 15", sweep_done, step_strobe, sample_code);
    end
    checks++;
    if (busy !== 1'b1 || duty_code !== 4'd0) begin
      errors++;
      $display("FAIL cont_wrap: got busy=%0b duty=%0d expected 1 0", busy, duty_code);
    end
    advance_to(544, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL cont_gap_strobe: got %0d expected 0", n); end
    tick();
    checks++;
    if (step_strobe !== 1'b1 || sample_code !== 4'd0 || sweep_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cont_next_strobe: got strobe=%0b sample=%0d done=%0b busy=%0b expected 1 0 0 1",
               step_strobe, sample_code, sweep_done, busy);
    end
    $display("continuous: wrapped, next strobe at cycle %0d", cyc);
    continuous = 1'b0;
    stop_run();
  endtask

  task automatic test_abort();
    int n, busy_seen;
    do_start();
    advance_to(20, n);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || duty_code !== 4'd0 || pwm_out !== 1'b0 || step_strobe !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%0b duty=%0d pwm=%0b strobe=%0b expected 0 0 0 0",
               busy, duty_code, pwm_out, step_strobe);
    end
    busy_seen = 0;
    n = 0;
    while (cyc < 81) begin
      tick();
      if (step_strobe === 1'b1) n++;
      if (busy === 1'b1) busy_seen++;
    end
    checks++;
    if (n !== 0 || busy_seen !== 0) begin
      errors++;
      $display("FAIL abort_stays_idle: got strobes=%0d busy_cycles=%0d expected 0 0", n, busy_seen);
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle: got busy=%0b expected 0", busy); end
    $display("abort: idle after stop, start+stop ignored");
  endtask

  task automatic test_stop_terminal();
    int n;
    do_start();
    advance_to(64, n);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (step_strobe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stopterm_strobe: got strobe=%0b busy=%0b expected 0 0", step_strobe, busy);
    end
    checks++;
    if (sample_code !== 4'd0) begin errors++; $display("FAIL stopterm_sample_hold: got %0d expected 0", sample_code); end
    do_start();
    advance_to(512, n);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (step_strobe !== 1'b0 || sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL stopterm_last: got strobe=%0b done=%0b expected 0 0", step_strobe, sweep_done);
    end
    checks++;
    if (sample_code !== 4'd14) begin errors++; $display("FAIL stopterm_last_sample: got %0d expected 14", sample_code); end
    $display("stop_terminal: no strobe, sample held at %0d", sample_code);
  endtask

  task automatic test_start_during_run();
    int n;
    do_start();
    advance_to(10, n);
    start = 1'b1;
    advance_to(16, n);
    start = 1'b0;
    checks++;
    if (duty_code !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rerun_state: got duty=%0d busy=%0b expected 0 1", duty_code, busy);
    end
    advance_to(32, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL rerun_early_strobe: got %0d expected 0", n); end
    tick();
    checks++;
    if (step_strobe !== 1'b1 || sample_code !== 4'd0 || duty_code !== 4'd1) begin
      errors++;
      $display("FAIL rerun_strobe_c33: got strobe=%0b sample=%0d duty=%0d expected 1 0 1",
               step_strobe, sample_code, duty_code);
    end
    $display("start_during_run: strobe unchanged at cycle %0d", cyc);
    stop_run();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    do_start();
    advance_to(230, n);
    checks++;
    if (duty_code !== 4'd7) begin errors++; $display("FAIL rstmid_duty: got %0d expected 7", duty_code); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({pwm_out, duty_code, sample_code, step_strobe, sweep_done, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b expected all zero",
               {pwm_out, duty_code, sample_code, step_strobe, sweep_done, busy});
    end
    do_start();
    checks++;
    if (busy !== 1'b1 || duty_code !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_restart: got busy=%0b duty=%0d expected 1 0", busy, duty_code);
    end
    advance_to(32, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL rstmid_early_strobe: got %0d expected 0", n); end
    tick();
    checks++;
    if (step_strobe !== 1'b1 || sample_code !== 4'd0 || duty_code !== 4'd1) begin
      errors++;
      $display("FAIL rstmid_strobe_c33: got strobe=%0b sample=%0d duty=%0d expected 1 0 1",
               step_strobe, sample_code, duty_code);
    end
    $display("reset_mid_sweep: restart strobe at cycle %0d", cyc);
    stop_run();
  endtask

  initial begin
    test_reset();
    test_settle_timing();
    test_full_sweep();
    test_pwm_duty();
    test_continuous();
    test_abort();
    test_stop_terminal();
    test_start_during_run();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_gen.md
Name: pwm_ramp_gen

Overview:
- Stimulus side of the discrete ADC loop: produces the PWM drive for the external RC filter and the comparator's reference input.
- Sweeps a duty code upward from 0 to full scale, holding each code for a fixed number of PWM periods so the filter output can settle.
- At the end of each settle window, pulses a strobe and presents the settled code. The comparator-capture logic uses these to decide on and latch the conversion result.

Parameters:
- WIDTH, 8: duty code resolution in bits. One PWM period is 2^WIDTH clk cycles.
- SETTLE_PERIODS, 16: number of PWM periods each code is held before sampling. Must be ≥1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: begin a sweep. Sampled only in IDLE.
- stop, input, 1: abort the sweep and return to IDLE.
- continuous, input, 1: when 1, the sweep wraps to code 0 after full scale instead of stopping. Sampled only at the sweep end.
- pwm_out, output, 1: PWM drive to the RC filter.
- duty_code, output, WIDTH: code currently being driven.
- sample_code, output, WIDTH: code whose settle window just ended. Valid while step_strobe=1.
- step_strobe, output, 1: one-cycle pulse marking the end of a settle window.
- sweep_done, output, 1: one-cycle pulse, coincident with the full-scale code's step_strobe.
- busy, output, 1: high in the RUN state.

Behaviour:
- Reset (synchronous, mid-operation included):
  - State goes to IDLE.
  - All counters, duty_code, sample_code, pwm_out, step_strobe, sweep_done and busy are cleared to 0.
- States:
  - IDLE: pwm_out=0, busy=0, counters held at 0.
  - IDLE→RUN: when start=1 and stop=0 at a clock edge.
  - First RUN cycle: busy=1, duty_code=0, pwm_cnt=0, period_cnt=0.
- Counters:
  - pwm_cnt runs 0..2^WIDTH-1 and wraps.
  - period_cnt increments when pwm_cnt wraps, and runs 0..SETTLE_PERIODS-1.
- PWM waveform:
  - In each PWM period, pwm_out is high for exactly duty_code consecutive cycles, starting at the first cycle of the period, and low for the remainder.
  - duty_code=0 gives a constant low. Full-scale code gives high for 2^WIDTH-1 of 2^WIDTH cycles.
- Terminal cycle: the RUN cycle with pwm_cnt=2^WIDTH-1 and period_cnt=SETTLE_PERIODS-1. At the edge ending it:
  - sample_code <= duty_code;
  - step_strobe <= 1 for one cycle;
  - duty_code <= duty_code+1; the new code takes effect at the start of the next PWM period, and counters reset to 0.
- Sweep end: if the terminal cycle occurs with duty_code=2^WIDTH-1, sweep_done pulses together with step_strobe. Then:
  - continuous=1: duty_code wraps to 0 and the block stays in RUN with no gap cycle.
  - continuous=0: the block goes to IDLE; busy=0 and pwm_out=0 in the strobe cycle.
- Latency: the first step_strobe occurs SETTLE_PERIODS·2^WIDTH cycles after the edge that accepted start.
- stop=1 in RUN:
  - Next cycle is IDLE with outputs as in reset, except sample_code, which holds its value.
  - If stop coincides with a terminal cycle, stop wins: no step_strobe and no sweep_done.
- start=1 while in RUN is ignored.
- start and stop asserted together in IDLE: the block stays in IDLE.
- step_strobe and sweep_done are never high for more than one consecutive cycle.

Test Plan:
- Settle timing (WIDTH=4, SETTLE_PERIODS=2): start pulse accepted at edge 0.
  - Required: busy=1 from cycle 1.
  - Required: first step_strobe at cycle 33 with sample_code=0 and duty_code=1 in the same cycle.
  - Required: next strobe at cycle 65 with sample_code=1.
- Full single sweep (WIDTH=4, SETTLE_PERIODS=2, continuous=0):
  - Required: 16 strobes with sample_code 0..15.
  - Required: sweep_done together with the last strobe at cycle 513, sample_code=15.
  - Required: busy=0 and pwm_out=0 from cycle 513.
- PWM duty:
  - duty_code=5 (WIDTH=4): exactly 5 high cycles, then 11 low, in every period.
  - duty_code=0: pwm_out never high.
  - duty_code=15: exactly 15 high cycles per 16.
- Continuous mode (continuous=1):
  - Required: after sweep_done, duty_code=0 the next cycle, busy stays 1, and the next strobe comes 32 cycles later with sample_code=0.
- Abort:
  - stop asserted mid-window: IDLE next cycle, no strobe.
  - stop on a terminal cycle: step_strobe and sweep_done stay 0.
  - start asserted during RUN: no change to duty_code or counters.
- Reset mid-sweep (synchronous reset at duty_code=7): all outputs 0 next cycle. A subsequent start restarts from code 0 with the exact settle-timing sequence above.
